// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - fully-connected layer sequencer over the shared macc/sigmoid datapath
// Buffers N operands, then per neuron fetches N weights and accumulates, emitting sigmoid(acc).
module layer_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_DEPTH   = 16,
  parameter int IDX_W      = 4,
  parameter int WADDR_W    = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDX_W:0]        num_inputs,
  input  logic [7:0]            num_neurons,
  input  logic [WADDR_W-1:0]    w_base,
  input  logic                  src_empty,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_de,
  output logic [WADDR_W-1:0]    w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic [DATA_WIDTH-1:0] macc_in0,
  output logic [DATA_WIDTH-1:0] macc_in1,
  output logic [DATA_WIDTH-1:0] macc_acc,
  input  logic [DATA_WIDTH-1:0] macc_out,
  output logic [DATA_WIDTH-1:0] sig_x,
  input  logic [DATA_WIDTH-1:0] sig_y,
  input  logic                  dst_full,
  output logic                  dst_en,
  output logic [31:0]           dst_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_ACC,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [IDX_W:0]     N_ONE     = 1;
  localparam logic [IDX_W:0]     N_MAX     = (IDX_W+1)'(IN_DEPTH);
  localparam logic [IDX_W-1:0]   K_ONE     = 1;
  localparam logic [WADDR_W-1:0] WADDR_ONE = 1;

  state_t                state, state_nxt;
  logic [IDX_W:0]        n_inputs_r;
  logic [7:0]            n_neurons_r;
  logic [WADDR_W-1:0]    w_base_r;
  logic [WADDR_W-1:0]    waddr;
  logic [DATA_WIDTH-1:0] acc;
  logic [IDX_W-1:0]      k;
  logic [7:0]            n;
  logic                  err_r;
  logic [DATA_WIDTH-1:0] op_buf [IN_DEPTH];

  logic start_bad;
  logic k_last;
  logic n_last;

  assign start_bad = (num_inputs == '0) || (num_inputs > N_MAX) || (num_neurons == 8'd0);
  assign k_last    = ({1'b0, k} == (n_inputs_r - N_ONE));
  assign n_last    = (n == (n_neurons_r - 8'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      n_inputs_r  <= '0;
      n_neurons_r <= '0;
      w_base_r    <= '0;
      waddr       <= '0;
      acc         <= '0;
      k           <= '0;
      n           <= '0;
      err_r       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_inputs_r  <= num_inputs;
            n_neurons_r <= num_neurons;
            w_base_r    <= w_base;
            err_r       <= start_bad;
            k           <= '0;
          end
        end
        S_LOAD: begin
          if (!src_empty) begin
            if (k_last) begin
              k     <= '0;
              n     <= '0;
              acc   <= '0;
              waddr <= w_base_r;
            end else begin
              k <= k + K_ONE;
            end
          end
        end
        S_ACC: begin
          acc   <= macc_out;
          waddr <= waddr + WADDR_ONE;
          if (!k_last) k <= k + K_ONE;
        end
        S_EMIT: begin
          if (!dst_full) begin
            acc <= '0;
            k   <= '0;
            if (!n_last) n <= n + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand register file has no reset; it is always fully rewritten by LOAD before use.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && !src_empty) op_buf[k] <= src_data;
  end

  always_comb begin
    state_nxt = state;
    src_de    = 1'b0;
    w_addr    = '0;
    macc_in0  = '0;
    macc_in1  = '0;
    macc_acc  = '0;
    sig_x     = '0;
    dst_en    = 1'b0;
    dst_data  = '0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = start_bad ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        src_de = !src_empty;
        if (!src_empty && k_last) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_addr    = waddr;
        state_nxt = S_ACC;
      end
      S_ACC: begin
        macc_in0  = w_data;
        macc_in1  = op_buf[k];
        macc_acc  = acc;
        state_nxt = k_last ? S_EMIT : S_FETCH;
      end
      S_EMIT: begin
        sig_x = acc;
        if (!dst_full) begin
          dst_en    = 1'b1;
          dst_data  = {sig_y, 8'b0, n};
          state_nxt = n_last ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
  assign err  = (state == S_DONE) && err_r;

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - scoreboard bench for layer_scheduler with ROM, FIFO, macc and sigmoid models
module tb_layer_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  num_inputs = '0;
  logic [7:0]  num_neurons = '0;
  logic [10:0] w_base = '0;
  logic        src_empty;
  logic [15:0] src_data;
  logic        src_de;
  logic [10:0] w_addr;
  logic [15:0] w_data = '0;
  logic [15:0] macc_in0, macc_in1, macc_acc, macc_out;
  logic [15:0] sig_x, sig_y;
  logic        dst_full;
  logic        dst_en;
  logic [31:0] dst_data;
  logic        busy, done, err;

  logic [15:0] rom [2048];
  logic [15:0] src_mem [64];
  logic [5:0]  rd_ptr = '0;
  logic [5:0]  wr_ptr = '0;
  logic        hold_empty = 1'b0;
  logic        hold_full = 1'b0;
  logic [31:0] prod;
  logic [10:0] prev_waddr = '0;

  logic [31:0] exp_dst[$];
  logic [31:0] exp_acc[$];
  logic [31:0] exp_addr[$];

  int n_checks = 0;
  int n_pass = 0;
  int src_de_cnt = 0;
  int dst_en_cnt = 0;
  int waddr_nz = 0;
  int viol = 0;

  layer_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .num_inputs(num_inputs), .num_neurons(num_neurons), .w_base(w_base),
    .src_empty(src_empty), .src_data(src_data), .src_de(src_de),
    .w_addr(w_addr), .w_data(w_data),
    .macc_in0(macc_in0), .macc_in1(macc_in1), .macc_acc(macc_acc), .macc_out(macc_out),
    .sig_x(sig_x), .sig_y(sig_y),
    .dst_full(dst_full), .dst_en(dst_en), .dst_data(dst_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sig_f(input logic [15:0] x);
    return x ^ 16'hA5A5;
  endfunction

  assign prod      = {16'b0, macc_in0} * {16'b0, macc_in1};
  assign macc_out  = macc_acc + prod[15:0];
  assign sig_y     = sig_f(sig_x);
  assign src_empty = (rd_ptr == wr_ptr) || hold_empty;
  assign src_data  = src_mem[rd_ptr];
  assign dst_full  = hold_full;

  always @(posedge clk) begin
    w_data <= rom[w_addr];
    if (src_de) rd_ptr <= rd_ptr + 6'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  always @(negedge clk) begin
    if (src_de) src_de_cnt++;
    if (src_de && src_empty) viol++;
    if (dst_en) begin
      dst_en_cnt++;
      if (dst_full) viol++;
      if (exp_dst.size() == 0) check("dst_unexpected", 32'(dst_en), 32'd0);
      else begin
        check("dst_data", dst_data, exp_dst.pop_front());
        check("sig_x", 32'(sig_x), exp_acc.pop_front());
      end
    end
    if (w_addr != '0) waddr_nz++;
    if (macc_in0 != '0) begin
      if (exp_addr.size() == 0) check("acc_unexpected", 32'(macc_in0), 32'd0);
      else check("w_addr", 32'(prev_waddr), exp_addr.pop_front());
    end
    prev_waddr = w_addr;
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_src_de"}, 32'(src_de), 32'd0);
    check({tag, "_dst_en"}, 32'(dst_en), 32'd0);
    check({tag, "_w_addr"}, 32'(w_addr), 32'd0);
    check({tag, "_macc"}, {macc_in0, macc_acc}, 32'd0);
    check({tag, "_sig_x"}, 32'(sig_x), 32'd0);
    check({tag, "_dst_data"}, dst_data, 32'd0);
  endtask

  task automatic run_layer(input string tag, input int nin, input int mneu, input int wb,
                           input int exp_lat, input bit fixed_ops, input bit stall,
                           input bit bstart, input int rst_at);
    logic [15:0] ops [16];
    logic [15:0] acc;
    logic [15:0] wv;
    logic [31:0] p;
    logic [7:0]  nb;
    int lat, de0, en0, wa0, v0, a, cnt;
    bit legal;
    legal = (nin >= 1) && (nin <= 16) && (mneu >= 1) && (mneu <= 255);
    wr_ptr = rd_ptr;
    cnt = legal ? nin : 1;
    for (int i = 0; i < cnt; i++) begin
      ops[i] = fixed_ops ? 16'(i + 3) : 16'($urandom_range(1, 200));
      src_mem[wr_ptr] = ops[i];
      wr_ptr = wr_ptr + 6'd1;
    end
    if (legal) begin
      for (int j = 0; j < mneu; j++) begin
        acc = '0;
        for (int i = 0; i < nin; i++) begin
          a  = (wb + j * nin + i) % 2048;
          wv = 16'(a + 1);
          p  = {16'b0, wv} * {16'b0, ops[i]};
          acc = acc + p[15:0];
          exp_addr.push_back(32'(a));
        end
        nb = 8'(j);
        exp_dst.push_back({sig_f(acc), 8'b0, nb});
        exp_acc.push_back(32'(acc));
      end
    end
    num_inputs  = 5'(nin);
    num_neurons = 8'(mneu);
    w_base      = 11'(wb);
    de0 = src_de_cnt; en0 = dst_en_cnt; wa0 = waddr_nz; v0 = viol;
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      #1;
      start      = bstart && (lat == 5);
      if (bstart && lat == 5) begin
        num_inputs  = 5'd1;
        num_neurons = 8'd7;
        w_base      = 11'd999;
      end
      hold_empty = stall && (lat >= 2) && (lat <= 6);
      hold_full  = stall && (lat >= 15) && (lat <= 18);
      if (rst_at == lat) begin
        reset = 1'b1;
        #1;
        check_idle_outputs({tag, "_rst"});
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_dst.delete();
        exp_acc.delete();
        exp_addr.delete();
        @(negedge clk);
        return;
      end
      @(negedge clk);
      if (lat == 1) check({tag, "_busy_run"}, 32'(busy), 32'd1);
    end while (!done && lat < 400);
    hold_empty = 1'b0;
    hold_full  = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(err), 32'(!legal));
    @(negedge clk);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_dst_left"}, 32'(exp_dst.size()), 32'd0);
    check({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
    check({tag, "_src_de_cnt"}, 32'(src_de_cnt - de0), 32'(legal ? nin : 0));
    check({tag, "_dst_en_cnt"}, 32'(dst_en_cnt - en0), 32'(legal ? mneu : 0));
    check({tag, "_viol"}, 32'(viol - v0), 32'd0);
    if (!legal) check({tag, "_waddr_act"}, 32'(waddr_nz - wa0), 32'd0);
    exp_dst.delete();
    exp_acc.delete();
    exp_addr.delete();
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 16'(i + 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);

    run_layer("t1_basic",   2, 1, 0,    8,   1, 0, 0, 0);
    run_layer("t2_two",     3, 2, 10,   18,  0, 0, 1, 0);
    run_layer("t3_stall",   3, 1, 40,   20,  0, 1, 0, 0);
    run_layer("t4_wrap",    4, 1, 2046, 14,  0, 0, 0, 0);
    run_layer("t5_n0",      0, 1, 5,    1,   0, 0, 0, 0);
    run_layer("t5_n17",     17, 1, 5,   1,   0, 0, 0, 0);
    run_layer("t5_m0",      2, 0, 5,    1,   0, 0, 0, 0);
    run_layer("t6_reset",   2, 2, 100,  0,   0, 0, 0, 9);
    run_layer("t6_after",   2, 1, 0,    8,   1, 0, 0, 0);
    run_layer("t7_full",    16, 3, 500, 116, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
